// File: rtl/program_loader.sv
// Byte-serial program loader: receives a length-prefixed, XOR-checksummed frame
// of 16-bit words and writes it into instruction memory, holding the core in reset.
module program_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, CHECK, DONE, ERR
   } state_t;

   localparam logic [16:0] CAP = 17'd1 << ADDR_W;

   state_t            state, state_nxt;
   logic [7:0]        len_hi, word_hi, csum;
   logic [15:0]       len;
   logic [ADDR_W:0]   idx, idx_nxt;
   logic [15:0]       n_full;
   logic              accept, overflow, words_left, start_ok;

   assign accept     = rx_valid && rx_ready;
   assign n_full     = {len_hi, rx_data};
   assign overflow   = {1'b0, n_full} > CAP;
   assign idx_nxt    = idx + 1'b1;
   // idx never exceeds 2^ADDR_W, so the extra bit keeps this compare wrap-free
   assign words_left = 17'(idx_nxt) < {1'b0, len};
   assign start_ok   = start && (state == IDLE || state == DONE || state == ERR);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start)  state_nxt = LEN_HI;
         LEN_HI:          if (accept) state_nxt = LEN_LO;
         LEN_LO:          if (accept) state_nxt = overflow ? ERR : (n_full == 16'd0) ? CHECK : WORD_HI;
         WORD_HI:         if (accept) state_nxt = WORD_LO;
         WORD_LO:         if (accept) state_nxt = words_left ? WORD_HI : CHECK;
         CHECK:           if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
         default:         state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready   = 1'b0;
      busy       = 1'b0;
      core_reset = 1'b1;
      done       = 1'b0;
      case (state)
         LEN_HI, LEN_LO, WORD_HI, WORD_LO, CHECK: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: the write strobe is registered so it lands the cycle after WORD_LO
   always_ff @(posedge clk) begin
      if (reset) begin
         len_hi     <= '0;
         word_hi    <= '0;
         len        <= '0;
         csum       <= '0;
         idx        <= '0;
         err_code   <= 2'b00;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start_ok) begin
            csum     <= '0;
            idx      <= '0;
            err_code <= 2'b00;
         end
         if (accept) begin
            case (state)
               LEN_HI: begin
                  len_hi <= rx_data;
                  csum   <= csum ^ rx_data;
               end
               LEN_LO: begin
                  len  <= n_full;
                  csum <= csum ^ rx_data;
                  if (overflow) err_code <= 2'b01;
               end
               WORD_HI: begin
                  word_hi <= rx_data;
                  csum    <= csum ^ rx_data;
               end
               WORD_LO: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= idx[ADDR_W-1:0];
                  imem_wdata <= {word_hi, rx_data};
                  idx        <= idx_nxt;
                  csum       <= csum ^ rx_data;
               end
               CHECK: if (rx_data != csum) err_code <= 2'b10;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a
// frame-level model of the expected writes and final status.
module tb_program_loader;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready, imem_we, core_reset, busy, done;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic [1:0]        err_code;

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .busy(busy), .done(done), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int got[$], exp_w[$];
   byte unsigned frm[$];
   bit exp_done;
   logic [1:0] exp_err;
   int exp_nb;

   always @(negedge clk) if (imem_we) got.push_back(int'({imem_addr, imem_wdata}));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected behaviour straight from the frame rules
   task automatic model();
      int n;
      byte unsigned ck;
      exp_w.delete();
      ck = 8'h00;
      n  = int'(frm[0]) * 256 + int'(frm[1]);
      if (n > (1 << ADDR_W)) begin
         exp_nb = 2; exp_err = 2'b01; exp_done = 1'b0;
         return;
      end
      for (int i = 0; i < 2 + 2 * n; i++) ck = ck ^ frm[i];
      for (int w = 0; w < n; w++)
         exp_w.push_back(((w % (1 << ADDR_W)) << 16) | (int'(frm[2+2*w]) << 8) | int'(frm[3+2*w]));
      exp_nb   = 3 + 2 * n;
      exp_done = (frm[exp_nb-1] == ck);
      exp_err  = exp_done ? 2'b00 : 2'b10;
   endtask

   task automatic build(input int n, input bit bad);
      byte unsigned ck, b;
      frm.delete();
      frm.push_back(8'(n >> 8));
      frm.push_back(8'(n & 255));
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         frm.push_back(b);
      end
      ck = 8'h00;
      foreach (frm[i]) ck = ck ^ frm[i];
      if (bad) ck = ck ^ 8'($urandom_range(255, 1));
      frm.push_back(ck);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_core_reset", core_reset, 1);
      chk("start_done", done, 0);
      chk("start_err", err_code, 0);
   endtask

   task automatic send(input byte unsigned b, input int gap);
      int t;
      rx_valid = 1'b0;
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ready_timeout", rx_ready, 1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic run(input string tag, input int gap);
      model();
      got.delete();
      pulse_start();
      for (int i = 0; i < exp_nb; i++) send(frm[i], gap);
      @(negedge clk);
      chk({tag, "_nwrites"}, got.size(), exp_w.size());
      for (int i = 0; i < exp_w.size(); i++)
         chk({tag, "_write"}, (i < got.size()) ? got[i] : -1, exp_w[i]);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_err"}, err_code, exp_err);
      chk({tag, "_core_reset"}, core_reset, !exp_done);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, rx_ready, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ready", rx_ready, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err_code, 0);
      chk("rst_we", imem_we, 0);
      reset = 1'b0;

      // rx_valid in IDLE must do nothing
      rx_data = 8'h55; rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_writes", got.size(), 0);

      frm = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h28, 8'h01, 8'h0E};
      run("basic", 0);
      chk("basic_w0", (got.size() > 0) ? got[0] : -1, 32'h002401);
      chk("basic_w1", (got.size() > 1) ? got[1] : -1, 32'h012801);

      frm = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h28, 8'h01, 8'h0F};
      run("badck", 0);
      chk("badck_err_const", err_code, 2'b10);

      frm = '{8'h01, 8'h01};
      run("ovf", 0);
      chk("ovf_err_const", err_code, 2'b01);

      frm = '{8'h00, 8'h00, 8'h00};
      run("zero", 0);

      build(256, 1'b0);
      run("n256", 0);

      frm = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h28, 8'h01, 8'h0E};
      run("gaps", 3);

      // reset between the two words of the basic frame
      got.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send(frm[i], 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", rx_ready, 0);
      chk("mid_rst_core_reset", core_reset, 1);
      chk("mid_rst_done", done, 0);
      repeat (3) @(negedge clk);
      chk("mid_rst_writes", got.size(), 1);
      run("after_rst", 1);

      repeat (20) begin
         build($urandom_range(6, 0), $urandom_range(3, 0) == 0);
         run("rand", $urandom_range(2, 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory address width; capacity is 2^ADDR_W 16-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load session.
REQ-005 rx_data  input  8  byte from host link.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_addr  output  ADDR_W  instruction-memory write address.
REQ-010 imem_wdata  output  16  instruction word to write.
REQ-011 core_reset  output  1  holds the processor core in reset while high.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  last session completed with a valid checksum.
REQ-014 err_code  output  2  00 none, 01 length overflow, 10 checksum mismatch.

Function
REQ-015 Frame format SHALL be: LEN_HI, LEN_LO (word count N, big-endian), then N words of 2 bytes each (high byte first), then 1 checksum byte.
REQ-016 A byte SHALL be accepted only on a cycle with rx_valid and rx_ready both high; rx_valid without rx_ready SHALL have no effect.
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, CHECK, DONE, ERR.
REQ-018 rx_ready SHALL be high exactly in LEN_HI, LEN_LO, WORD_HI, WORD_LO and CHECK.
REQ-019 busy SHALL be high in LEN_HI through CHECK and low otherwise.
REQ-020 IDLE, DONE or ERR with start high SHALL go to LEN_HI next cycle, clear done, err_code, running checksum and word index, and raise core_reset; start in any other state SHALL be ignored.
REQ-021 LEN_HI accept -> LEN_LO; LEN_LO accept -> ERR (err_code 01) if N > 2^ADDR_W, else CHECK if N == 0, else WORD_HI.
REQ-022 WORD_HI accept -> WORD_LO; WORD_LO accept -> WORD_HI if words remain, else CHECK.
REQ-023 On the cycle after each WORD_LO accept, imem_we SHALL pulse high for exactly one cycle with imem_addr = word index (0 for the first word, incrementing by 1) and imem_wdata = {high byte, low byte}.
REQ-024 imem_we SHALL never be high outside that one cycle per word; imem_addr and imem_wdata SHALL be don't-care when imem_we is low.
REQ-025 Running checksum SHALL be the XOR of every accepted byte from LEN_HI through the last WORD_LO, with an initial value of 0x00.
REQ-026 CHECK accept -> DONE if the byte equals the running checksum, else ERR with err_code 10.
REQ-027 DONE SHALL hold done=1 and core_reset=0 until reset or start; ERR SHALL hold core_reset=1 and err_code until reset or start.
REQ-028 core_reset SHALL be 0 only in DONE.
REQ-029 Word count SHALL be held in a 16-bit register, and the word index SHALL be wide enough to reach 2^ADDR_W without wrap.

Reset
REQ-030 reset SHALL force IDLE with core_reset=1, rx_ready=0, imem_we=0, busy=0, done=0, err_code=00, checksum 0x00 and word index 0, taking priority over start and over any byte handshake in the same cycle.
REQ-031 reset mid-session SHALL abort with no further imem_we pulse; words already written stay in memory.

Verification
REQ-032 start; bytes 00 02 24 01 28 01 0E -> imem_we pulses (addr 0, 0x2401) and (addr 1, 0x2801); DONE, done=1, core_reset=0, err_code=00.
REQ-033 Same frame with checksum 0x0F -> both writes occur; ERR, err_code=10, core_reset=1, done=0.
REQ-034 ADDR_W=8; bytes 01 01 -> ERR after LEN_LO with err_code=01, rx_ready=0, and no imem_we.
REQ-035 Bytes 00 00 00 -> DONE with no imem_we; random rx_valid gaps during REQ-032 -> identical writes and result.
REQ-036 Reset asserted between the two words of REQ-032 -> IDLE next cycle, exactly one write seen; a following start and the full frame then succeed.
